// File: rtl/mips_pkg.sv
// Shared MIPS constants: data width, opcode encodings, fetch reset defaults.
package mips_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [WORD_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [WORD_W-1:0] RESET_PC_DEF  = 32'h0000_0000;

  // Pseudo-direct jump target: region bits come from the delay-free PC+4.
  function automatic logic [WORD_W-1:0] jump_target(input logic [WORD_W-1:0] pc4,
                                                    input logic [WORD_W-1:0] instr);
    return {pc4[31:28], instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC priority mux: jump over taken branch over sequential PC+4.
module next_pc_sel
  import mips_pkg::*;
(
  input  logic [WORD_W-1:0] pc4,
  input  logic [WORD_W-1:0] br_tgt,
  input  logic [WORD_W-1:0] j_tgt,
  input  logic              take_j,
  input  logic              take_b,
  output logic [WORD_W-1:0] next_pc
);

  always_comb begin
    next_pc = pc4;
    if (take_j) begin
      next_pc = j_tgt;
    end else if (take_b) begin
      next_pc = br_tgt;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, redirect resolution and IF/ID pipeline register.
// Optional perf counters (perf_fetched, perf_bubbles) enabled by FETCH_PERF_CNT_EN.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch,
  input  logic              zero,
  input  logic              jump,
  input  logic [WORD_W-1:0] imm_sext,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [WORD_W-1:0] imem_addr,
  output logic [WORD_W-1:0] if_id_instr,
  output logic [WORD_W-1:0] if_id_pc4,
  output logic              if_id_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_bubbles,
`endif
  output logic [5:0]        opcode
);

  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] if_id_instr_q, if_id_instr_d;
  logic [WORD_W-1:0] if_id_pc4_q, if_id_pc4_d;
  logic              if_id_valid_q, if_id_valid_d;

  logic [WORD_W-1:0] pc4, br_tgt, j_tgt, next_pc;
  logic              take_j, take_b, redirect;

  assign pc4    = pc_q + 32'd4;
  assign br_tgt = if_id_pc4_q + {imm_sext[29:0], 2'b00};
  assign j_tgt  = jump_target(if_id_pc4_q, if_id_instr_q);

  // A bubble in IF/ID must never redirect, which also rules out back-to-back redirects.
  assign take_j   = jump & if_id_valid_q;
  assign take_b   = branch & zero & if_id_valid_q;
  assign redirect = take_j | take_b;

  next_pc_sel u_next_pc_sel (
    .pc4     (pc4),
    .br_tgt  (br_tgt),
    .j_tgt   (j_tgt),
    .take_j  (take_j),
    .take_b  (take_b),
    .next_pc (next_pc)
  );

  always_comb begin
    pc_d          = pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc4_d   = if_id_pc4_q;
    if_id_valid_d = if_id_valid_q;
    if (!stall) begin
      pc_d = next_pc;
      if (redirect) begin
        // Squash the wrong-path word fetched this cycle.
        if_id_instr_d = NOP_INSTR;
        if_id_valid_d = 1'b0;
      end else begin
        if_id_instr_d = imem_rdata;
        if_id_pc4_d   = pc4;
        if_id_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      if_id_instr_q <= NOP_INSTR;
      if_id_pc4_q   <= RESET_PC;
      if_id_valid_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_pc4   = if_id_pc4_q;
  assign if_id_valid = if_id_valid_q;
  assign opcode      = if_id_instr_q[31:26];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_bubbles_q, perf_bubbles_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_bubbles_d = perf_bubbles_q;
    if (!stall) begin
      if (redirect) begin
        perf_bubbles_d = perf_bubbles_q + 32'd1;
      end else begin
        perf_fetched_d = perf_fetched_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= 32'd0;
      perf_bubbles_q <= 32'd0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_bubbles_q <= perf_bubbles_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, PC wrap, beq taken/not-taken, jal, stall, reset.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, branch, zero, jump;
  logic [31:0] imm_sext;
  logic [31:0] imem_rdata, imem_addr, if_id_instr, if_id_pc4;
  logic        if_id_valid;
  logic [5:0]  opcode;
  logic [31:0] imem_rdata2, imem_addr2, if_id_instr2, if_id_pc4_2;
  logic        if_id_valid2;
  logic [5:0]  opcode2;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_bubbles, perf_fetched2, perf_bubbles2;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] addr);
    case (addr)
      32'h0000_0000: return 32'h2002_0005;
      32'h4000_000C: return 32'h0C00_0040;
      default:       return {8'h8C, addr[23:0]};
    endcase
  endfunction

  assign imem_rdata  = imem_word(imem_addr);
  assign imem_rdata2 = imem_word(imem_addr2);

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .branch      (branch),
    .zero        (zero),
    .jump        (jump),
    .imm_sext    (imm_sext),
    .imem_rdata  (imem_rdata),
    .imem_addr   (imem_addr),
    .if_id_instr (if_id_instr),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched(perf_fetched),
    .perf_bubbles(perf_bubbles),
`endif
    .opcode      (opcode)
  );

  // Second instance only exercises sequential PC wrap-around.
  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk         (clk),
    .rst         (rst),
    .stall       (1'b0),
    .branch      (1'b0),
    .zero        (1'b0),
    .jump        (1'b0),
    .imm_sext    (32'h0),
    .imem_rdata  (imem_rdata2),
    .imem_addr   (imem_addr2),
    .if_id_instr (if_id_instr2),
    .if_id_pc4   (if_id_pc4_2),
    .if_id_valid (if_id_valid2),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched(perf_fetched2),
    .perf_bubbles(perf_bubbles2),
`endif
    .opcode      (opcode2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic valid);
    check({tag, ".addr"}, imem_addr, addr);
    check({tag, ".instr"}, if_id_instr, instr);
    check({tag, ".pc4"}, if_id_pc4, pc4);
    check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, valid});
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0; imm_sext = 32'h0;

    // Reset held for two edges
    step();
    check_ifid("rst1", 32'h0, 32'h0, 32'h0, 1'b0);
    step();
    check_ifid("rst2", 32'h0, 32'h0, 32'h0, 1'b0);
    check("wrap0", imem_addr2, 32'hFFFF_FFF8);
    rst = 1'b0;

    step();  // edge 3
    check_ifid("first", 32'h4, 32'h2002_0005, 32'h4, 1'b1);
    check("first.opcode", {26'd0, opcode}, 32'h08);
    check("wrap1", imem_addr2, 32'hFFFF_FFFC);
    step();  // edge 4
    check("wrap2", imem_addr2, 32'h0000_0000);
    check("wrap2.pc4", if_id_pc4_2, 32'h0000_0000);
    step();  // edge 5
    check("wrap3", imem_addr2, 32'h0000_0004);
    check_ifid("seq", 32'hC, 32'h8C00_0008, 32'hC, 1'b1);
    step();  // edge 6
    check_ifid("pre_beq", 32'h10, 32'h8C00_000C, 32'h10, 1'b1);

    // Taken beq: 0x10 + (-2 << 2) = 0x8
    branch = 1'b1; zero = 1'b1; imm_sext = 32'hFFFF_FFFE;
    step();  // edge 7
    check_ifid("beq_taken", 32'h8, 32'h0, 32'h10, 1'b0);
    step();  // edge 8: bubble in IF/ID, branch ignored
    check_ifid("beq_bubble", 32'hC, 32'h8C00_0008, 32'hC, 1'b1);

    // Not-taken beq
    zero = 1'b0;
    step();  // edge 9
    check_ifid("beq_nt", 32'h10, 32'h8C00_000C, 32'h10, 1'b1);

    // Long branch to 0x4000_000C: (0x4000_000C - 0x10) >> 2
    zero = 1'b1; imm_sext = 32'h0FFF_FFFF;
    step();  // edge 10
    check_ifid("beq_far", 32'h4000_000C, 32'h0, 32'h10, 1'b0);
    branch = 1'b0; zero = 1'b0;
    step();  // edge 11
    check_ifid("jal_fetch", 32'h4000_0010, 32'h0C00_0040, 32'h4000_0010, 1'b1);
    check("jal.opcode", {26'd0, opcode}, 32'h03);

    // jal with a simultaneous taken branch: jump wins
    jump = 1'b1; branch = 1'b1; zero = 1'b1; imm_sext = 32'h0000_0010;
    #1;
    check("jal.link", if_id_pc4, 32'h4000_0010);
    step();  // edge 12
    check("jal.addr", imem_addr, 32'h4000_0100);
    check("jal.instr", if_id_instr, 32'h0);
    check("jal.valid", {31'd0, if_id_valid}, 32'd0);
    branch = 1'b0; zero = 1'b0;
    step();  // edge 13: jump ignored on bubble
    check_ifid("post_jal", 32'h4000_0104, 32'h8C00_0100, 32'h4000_0104, 1'b1);

    // Stall with a valid jump pending: nothing moves
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_ifid("stall", 32'h4000_0104, 32'h8C00_0100, 32'h4000_0104, 1'b1);
    end

`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", perf_fetched, 32'd8);
    check("perf_bubbles", perf_bubbles, 32'd3);
`endif

    // Reset while stalled
    rst = 1'b1;
    step();
    check_ifid("rst_stall", 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched_rst", perf_fetched, 32'd0);
    check("perf_bubbles_rst", perf_bubbles, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage with PC register, next-PC selection and IF/ID pipeline register; sits directly upstream of the main control unit.
- Drives the instruction memory address and latches the fetched word plus PC+4 into IF/ID.
- Exposes the IF/ID opcode field to control decode, and accepts redirect requests (branch/jump/jal) resolved in ID.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, word inserted into IF/ID on flush/reset (sll $0,$0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard hold: PC and IF/ID keep their values.
- branch  in  1  beq decoded in ID.
- zero  in  1  ID register-compare equal flag; branch taken = branch & zero.
- jump  in  1  j or jal decoded in ID.
- imm_sext  in  32  sign-extended 16-bit immediate of ID instruction.
- imem_rdata  in  32  instruction word at imem_addr (combinational read).
- imem_addr  out  32  current PC.
- if_id_instr  out  32  registered instruction.
- if_id_pc4  out  32  registered PC+4 of that instruction; also the jal link value.
- if_id_valid  out  1  0 when IF/ID holds an inserted bubble.
- opcode  out  6  if_id_instr[31:26], to control decode.

Behaviour:
- Reset (rst=1 at edge): pc<=RESET_PC, if_id_instr<=NOP_INSTR, if_id_pc4<=RESET_PC, if_id_valid<=0. Reset overrides stall and redirect; mid-operation reset discards the in-flight instruction.
- imem_addr = pc. pc[1:0] stays 2'b00 whenever RESET_PC is word-aligned.
- pc4 = pc + 4, 32-bit modulo: 32'hFFFF_FFFC wraps to 32'h0.
- Redirect targets are computed from IF/ID contents:
  - br_tgt = if_id_pc4 + (imm_sext << 2), modulo 2^32.
  - j_tgt = {if_id_pc4[31:28], if_id_instr[25:0], 2'b00}.
- Redirect conditions are qualified by if_id_valid, so a bubble never redirects:
  - take_j = jump & if_id_valid.
  - take_b = branch & zero & if_id_valid.
- Next-PC priority: take_j > take_b > pc4.
- Per edge, when not in reset:
  - stall=1: pc, if_id_* hold. Any redirect is ignored this cycle and re-evaluated once stall drops.
  - stall=0 and redirect: pc<=target; IF/ID<=NOP_INSTR, pc4 unchanged-don't-care, valid<=0 (one-bubble penalty, squashes the wrong-path fetch).
  - stall=0, no redirect: pc<=pc4; if_id_instr<=imem_rdata; if_id_pc4<=pc4; valid<=1.
- Latency: instruction at PC appears in IF/ID one cycle after imem_addr=PC. Taken branch/jump costs exactly one bubble.
- Since redirect is gated by valid, back-to-back redirects are impossible: the cycle after a redirect always holds a bubble.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched[31:0] and perf_bubbles[31:0].
  - perf_fetched counts non-stalled, non-redirect edges.
  - perf_bubbles counts redirect edges.
  - Both reset to 0 on rst, wrap at 2^32, and hold during stall.
- Undefined: ports and counters are absent; core behaviour is identical.

Decomposition:
- Shared package mips_pkg:
  - opcode constants OP_RTYPE 6'h00, OP_J 6'h02, OP_JAL 6'h03, OP_BEQ 6'h04, OP_LW 6'h23, OP_SW 6'h2B.
  - NOP_INSTR and RESET_PC defaults.
  - WORD_W=32.
- One sub-module: next_pc_sel, purely combinational. Inputs pc4, br_tgt, j_tgt, take_j, take_b. Output next_pc. Reusable by a later delay-slot variant.

Test Plan:
- Reset: rst=1 for 2 cycles then release, imem returns 32'h2002_0005 at addr 0 → imem_addr=0 during reset; after first edge post-release if_id_instr=32'h2002_0005, if_id_pc4=4, valid=1, imem_addr=4.
- Sequential wrap: RESET_PC=32'hFFFF_FFF8, no stalls → imem_addr sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Taken beq: IF/ID pc4=32'h10, branch=1, zero=1, imm_sext=32'hFFFF_FFFE → next imem_addr=32'h8, if_id_valid=0, if_id_instr=NOP. The following cycle's branch=1 is ignored (valid=0).
- Not-taken beq: branch=1, zero=0 → imem_addr advances by 4, no bubble.
- jal: IF/ID instr=32'h0C00_0040, pc4=32'h4000_0010, jump=1 → next imem_addr=32'h4000_0100, bubble inserted, link value if_id_pc4 observed as 32'h4000_0010 in the redirect cycle.
- Stall then reset: stall=1 for 3 cycles with jump=1 → pc and IF/ID constant, no redirect. Then rst=1 while stall=1 → pc=RESET_PC, valid=0. With FETCH_PERF_CNT_EN, both counters read 0 after reset.
